stream_rr_arbiter: RTL and testbench

//  Round-robin arbiter that merges p_num_reqs val/rdy message streams onto one
//  val/rdy output stream. Sits between several producers, e.g. TestIstream

---
 rtl/stream_arb_pkg.sv | 22 ++
 rtl/rr_arbiter_core.sv | 37 +++
 rtl/stream_rr_arbiter.sv | 86 ++++++++
 tb/tb_stream_rr_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared helpers for the round-robin stream arbiter: pointer advance,
// index width, and per-input trace characters.
package stream_arb_pkg;

  // Next priority pointer after index ptr has been granted, modulo n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

  // Index width for n sources; at least one bit, so n=1 stays legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd2) ? 32'($clog2(n)) : 32'd1;
  endfunction

  // Trace glyph: '*' granted, '#' valid but stalled, '.' idle.
  function automatic byte trace_char(input logic gnt, input logic val);
    if (gnt) return 8'h2A;
    if (val) return 8'h23;
    return 8'h2E;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin search: first requester at or after i_ptr wins;
// the grant is gated by i_en, while the winner index is always reported.
module rr_arbiter_core
  import stream_arb_pkg::*;
#(
  parameter int unsigned p_num_reqs = 4
) (
  input  logic [p_num_reqs-1:0]                   i_req,
  input  logic [idx_width(p_num_reqs)-1:0]        i_ptr,
  input  logic                                    i_en,
  output logic [p_num_reqs-1:0]                   o_gnt_c,
  output logic [idx_width(p_num_reqs)-1:0]        o_idx_c
);

  localparam int unsigned IDX_W = idx_width(p_num_reqs);

  int unsigned w_pos;
  logic        w_found;

  always_comb begin
    o_gnt_c = '0;
    o_idx_c = '0;
    w_found = 1'b0;
    w_pos   = 32'd0;
    // Walk ptr, ptr+1, ... wrapping at p_num_reqs; first hit wins.
    for (int k = 0; k < int'(p_num_reqs); k++) begin
      w_pos = 32'(i_ptr) + 32'(k);
      if (w_pos >= p_num_reqs) w_pos = w_pos - p_num_reqs;
      if (!w_found && i_req[IDX_W'(w_pos)]) begin
        w_found = 1'b1;
        o_idx_c = IDX_W'(w_pos);
      end
    end
    if (i_en && w_found) o_gnt_c = p_num_reqs'(1) << o_idx_c;
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of p_num_reqs val/rdy streams into one registered stream.
// Optional STREAM_RR_ARBITER_TRACE_EN adds a per-cycle `string trace`.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter type         t_msg      = logic [31:0],
  parameter int unsigned p_num_reqs = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  t_msg                                 istream_msg [p_num_reqs],
  input  logic [p_num_reqs-1:0]                istream_val,
  output logic [p_num_reqs-1:0]                istream_rdy,
  output t_msg                                 ostream_msg,
  output logic                                 ostream_val,
  input  logic                                 ostream_rdy,
  output logic [idx_width(p_num_reqs)-1:0]     grant_idx
);

  localparam int unsigned IDX_W = idx_width(p_num_reqs);

  t_msg             r_msg;
  logic             r_val;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;

  logic                  w_load_en;
  logic                  w_hs;
  logic [p_num_reqs-1:0] w_gnt;
  logic [IDX_W-1:0]      w_idx;

  // Buffer accepts when empty or draining this cycle; never during reset.
  assign w_load_en = (~r_val | ostream_rdy) & ~rst;

  rr_arbiter_core #(
    .p_num_reqs(p_num_reqs)
  ) u_core (
    .i_req   (istream_val),
    .i_ptr   (r_ptr),
    .i_en    (w_load_en),
    .o_gnt_c (w_gnt),
    .o_idx_c (w_idx)
  );

  assign istream_rdy = w_gnt;
  assign w_hs        = |(istream_val & w_gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msg <= '0;
      r_val <= 1'b0;
      r_idx <= '0;
      r_ptr <= '0;
    end else if (w_hs) begin
      r_msg <= istream_msg[w_idx];
      r_val <= 1'b1;
      r_idx <= w_idx;
      r_ptr <= IDX_W'(rr_next(32'(w_idx), p_num_reqs));
    end else if (ostream_rdy) begin
      r_val <= 1'b0;
    end
  end

  assign ostream_msg = r_msg;
  assign ostream_val = r_val;
  assign grant_idx   = r_idx;

`ifdef STREAM_RR_ARBITER_TRACE_EN
  string trace;

  // Input glyphs, separator, then the departing message or equal-width blanks.
  always_comb begin
    trace = "";
    for (int i = 0; i < int'(p_num_reqs); i++)
      trace = {trace, $sformatf("%c", trace_char(w_gnt[i], istream_val[i]))};
    trace = {trace, " > "};
    if (r_val && ostream_rdy) begin
      trace = {trace, $sformatf("%x", r_msg)};
    end else begin
      for (int i = 0; i < ($bits(t_msg) + 3) / 4; i++) trace = {trace, " "};
    end
  end
`else
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed vector table, hand-written
// stall/reset sequences, and randomized traffic against a reference model.
module tb_stream_rr_arbiter;

  localparam int N = 4;
  localparam int RAND_CYC = 10000;
  localparam int DRAIN_AT = RAND_CYC - 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      istream_msg [N];
  logic [N-1:0]     istream_val = '0;
  logic [N-1:0]     istream_rdy;
  logic [31:0]      ostream_msg;
  logic             ostream_val;
  logic             ostream_rdy = 1'b0;
  logic [1:0]       grant_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_rr_arbiter #(
    .t_msg      (logic [31:0]),
    .p_num_reqs (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .istream_msg (istream_msg),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .ostream_msg (ostream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .grant_idx   (grant_idx)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] val, input logic [7:0] base, input logic ordy);
    istream_val = val;
    for (int i = 0; i < N; i++) istream_msg[i] = 32'(base) + 32'(i);
    ostream_rdy = ordy;
  endtask

  task automatic check_out(input string tag, input logic val, input logic [31:0] msg,
                           input logic [1:0] idx);
    chk({tag, "_val"}, 64'(ostream_val), 64'(val));
    chk({tag, "_msg"}, 64'(ostream_msg), 64'(msg));
    chk({tag, "_idx"}, 64'(grant_idx), 64'(idx));
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic reset_dut();
    rst = 1'b1;
    drive(4'hF, 8'h00, 1'b1);
    @(posedge clk); #1;
    check_out("reset", 1'b0, 32'h0, 2'd0);
    chk("reset_rdy", 64'(istream_rdy), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'h0, 8'h00, 1'b1);
  endtask

  typedef struct {
    logic [3:0]  val;
    logic [7:0]  base;
    logic        ordy;
    logic [3:0]  rdy;
    logic        oval;
    logic [31:0] omsg;
    logic [1:0]  idx;
  } vec_t;

  vec_t tbl [15];

  // Reference model and scoreboard state for the random phase.
  logic         m_val;
  logic [31:0]  m_msg;
  int           m_idx, m_ptr;
  logic         m_load;
  int           w, j, src;
  logic [N-1:0] exp_rdy, hs;
  logic [N-1:0] src_val;
  logic [31:0]  src_msg [N];
  int           src_seq [N], exp_seq [N], sent [N], rcvd [N], waits [N];

  initial begin
    for (int i = 0; i < N; i++) istream_msg[i] = '0;

    // Round-robin burst from reset, drain, single source, pointer wrap, stall.
    for (int k = 0; k < 8; k++)
      tbl[k] = '{4'hF, 8'h10, 1'b1, 4'(1 << (k % 4)), 1'b1, 32'(32'h10 + k % 4), 2'(k % 4)};
    tbl[8]  = '{4'h0, 8'h10, 1'b1, 4'h0, 1'b0, 32'h13, 2'd3};
    tbl[9]  = '{4'h4, 8'hA0, 1'b1, 4'h4, 1'b1, 32'hA2, 2'd2};
    tbl[10] = '{4'h0, 8'hA0, 1'b1, 4'h0, 1'b0, 32'hA2, 2'd2};
    tbl[11] = '{4'h3, 8'hA0, 1'b1, 4'h1, 1'b1, 32'hA0, 2'd0};
    tbl[12] = '{4'h3, 8'hA0, 1'b0, 4'h0, 1'b1, 32'hA0, 2'd0};
    tbl[13] = '{4'h3, 8'hA0, 1'b1, 4'h2, 1'b1, 32'hA1, 2'd1};
    tbl[14] = '{4'h0, 8'hA0, 1'b1, 4'h0, 1'b0, 32'hA1, 2'd1};

    #1;
    reset_dut();
    for (int r = 0; r < 15; r++) begin
      drive(tbl[r].val, tbl[r].base, tbl[r].ordy);
      #3;
      chk($sformatf("tbl%0d_rdy", r), 64'(istream_rdy), 64'(tbl[r].rdy));
      @(posedge clk); #1;
      check_out($sformatf("tbl%0d", r), tbl[r].oval, tbl[r].omsg, tbl[r].idx);
    end

    // Stall with 0x11 buffered: everything holds, then grant moves to in[2].
    reset_dut();
    drive(4'hF, 8'h10, 1'b1);
    #3; chk("stall_pre0_rdy", 64'(istream_rdy), 64'h1);
    @(posedge clk); #1;
    #3; chk("stall_pre1_rdy", 64'(istream_rdy), 64'h2);
    @(posedge clk); #1;
    check_out("stall_pre", 1'b1, 32'h11, 2'd1);
    drive(4'hF, 8'h10, 1'b0);
    for (int s = 0; s < 3; s++) begin
      #3; chk($sformatf("stall%0d_rdy", s), 64'(istream_rdy), 64'h0);
      @(posedge clk); #1;
      check_out($sformatf("stall%0d", s), 1'b1, 32'h11, 2'd1);
    end
    drive(4'hF, 8'h10, 1'b1);
    #3; chk("release_rdy", 64'(istream_rdy), 64'h4);
    @(posedge clk); #1;
    check_out("release", 1'b1, 32'h12, 2'd2);

    // Asynchronous reset mid-cycle while the buffer is full.
    #2 rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 32'h0, 2'd0);
    chk("async_rst_rdy", 64'(istream_rdy), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #3; chk("post_rst_rdy", 64'(istream_rdy), 64'h1);
    @(posedge clk); #1;
    check_out("post_rst", 1'b1, 32'h10, 2'd0);

    // Randomized traffic against the behavioural model.
    reset_dut();
    m_val = 1'b0; m_msg = '0; m_idx = 0; m_ptr = 0;
    src_val = '0;
    for (int i = 0; i < N; i++) begin
      src_msg[i] = '0; src_seq[i] = 0; exp_seq[i] = 0;
      sent[i] = 0; rcvd[i] = 0; waits[i] = 0;
    end
    for (int c = 0; c < RAND_CYC; c++) begin
      for (int i = 0; i < N; i++) istream_msg[i] = src_msg[i];
      istream_val = src_val;
      ostream_rdy = (c >= DRAIN_AT) ? 1'b1 : ($urandom_range(0, 9) < 7);
      #3;
      m_load = !m_val || ostream_rdy;
      w = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (w < 0 && src_val[j]) w = j;
      end
      exp_rdy = (m_load && w >= 0) ? 4'(1 << w) : 4'h0;
      chk("rand_rdy", 64'(istream_rdy), 64'(exp_rdy));

      if (ostream_val && ostream_rdy) begin
        src = int'(ostream_msg[31:24]);
        if (src < N) begin
          chk("rand_order", 64'(ostream_msg[23:0]), 64'(exp_seq[src]));
          exp_seq[src]++;
          rcvd[src]++;
        end else begin
          chk("rand_src", 64'(src), 64'(N - 1));
        end
      end

      hs = istream_val & istream_rdy;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          chk("rand_wait", 64'(waits[i] <= N - 1), 64'h1);
          waits[i] = 0;
          sent[i]++;
        end
      end
      if (hs != '0) begin
        for (int i = 0; i < N; i++) if (src_val[i] && !hs[i]) waits[i]++;
      end

      if (m_load && w >= 0) begin
        m_msg = src_msg[w];
        m_val = 1'b1;
        m_idx = w;
        m_ptr = (w + 1) % N;
      end else if (ostream_rdy) begin
        m_val = 1'b0;
      end

      @(posedge clk); #1;
      chk("rand_oval", 64'(ostream_val), 64'(m_val));
      chk("rand_omsg", 64'(ostream_msg), 64'(m_msg));
      chk("rand_idx",  64'(grant_idx),   64'(m_idx));

      for (int i = 0; i < N; i++) begin
        if (hs[i]) src_val[i] = 1'b0;
        if (!src_val[i] && c < DRAIN_AT && $urandom_range(0, 9) < 6) begin
          src_msg[i] = {8'(i), 24'(src_seq[i])};
          src_seq[i]++;
          src_val[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rand_count%0d", i), 64'(rcvd[i]), 64'(sent[i]));
      chk($sformatf("rand_all_sent%0d", i), 64'(sent[i]), 64'(src_seq[i]));
    end
    chk("rand_drained", 64'(ostream_val), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
